pixel_frame_streamer: RTL and testbench
=======================================

Name: pixel_frame_streamer

Overview:
- Transmit side of the Tracker pixel interface. It reads one frame of 24-bit RGB pixels from a frame-buffer memory port, in raster order.
- Each pixel goes out as a single-cycle i_RGB/i_pixelVAL beat, with a programmable idle gap after it.
- After the last pixel it waits for the Tracker's point-valid pulse before it counts the frame and starts the next one.
- Sits between the SRAM/frame-buffer read controller and Tracker, in the 25 MHz pixel clock domain.

Parameters:
- H_ACT, 640, active pixels per line.
- V_ACT, 480, active lines per frame.
- ADDR_W, 19, frame-buffer word address width; must satisfy 2^ADDR_W >= H_ACT*V_ACT.
- PIX_GAP, 2, idle cycles inserted after every emitted pixel; 0 is legal.

Ports:
- clk  in  1  pixel clock, 25 MHz.
- rst_n  in  1  asynchronous, active-low reset.
- i_start  in  1  level; sampled in IDLE and again at frame completion (continuous mode while held high).
- o_mem_req  out  1  one-cycle read request.
- o_mem_addr  out  ADDR_W  read address, valid while o_mem_req=1.
- i_mem_rvalid  in  1  read data valid, one cycle per request, arriving >=1 cycle after o_mem_req.
- i_mem_rdata  in  24  {R,G,B} read data.
- o_RGB  out  24  pixel to Tracker i_RGB.
- o_pixelVAL  out  1  pixel strobe to Tracker i_pixelVAL.
- o_pixH  out  10  column of current/last emitted pixel.
- o_pixV  out  10  line of current/last emitted pixel.
- o_sof  out  1  high with o_pixelVAL for pixel (0,0).
- o_eof  out  1  high with o_pixelVAL for pixel (H_ACT-1,V_ACT-1).
- i_track_valid  in  1  Tracker o_valid.
- o_busy  out  1  high in every state except IDLE.
- o_frame_cnt  out  16  completed frames, wraps 0xFFFF->0.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - All outputs are 0, including o_RGB, o_mem_addr, the H/V counters and o_frame_cnt.
  - Reset mid-frame abandons the frame. Any i_mem_rvalid arriving after reset and before the next request is ignored.
- States: IDLE, REQ, WAIT, EMIT, GAP, WAIT_TRK.
- IDLE: when i_start=1, clear H, V and the address, then go to REQ.
- REQ: o_mem_req=1 and o_mem_addr = linear address (V*H_ACT+H, kept as an incrementing counter, no multiplier). Go to WAIT.
- WAIT: hold until i_mem_rvalid=1, register i_mem_rdata into o_RGB, then go to EMIT. o_mem_req is 0 here; exactly one request is outstanding.
- EMIT (one cycle):
  - o_pixelVAL=1, and o_pixH/o_pixV show the pixel's coordinates.
  - o_sof/o_eof are decoded from the coordinates.
  - Advance H; on H=H_ACT-1, wrap H to 0 and increment V.
  - Next state: GAP if PIX_GAP>0. If PIX_GAP=0, go to WAIT_TRK after the last pixel, otherwise REQ.
- GAP: count PIX_GAP cycles, then go to REQ, or to WAIT_TRK if the last pixel was emitted.
- WAIT_TRK: hold until i_track_valid=1. On it:
  - o_frame_cnt += 1.
  - If i_start=1, restart at REQ with H=V=addr=0 (i_start is sampled the same cycle).
  - Otherwise go to IDLE.
- Outputs between pixels:
  - o_RGB, o_pixH and o_pixV hold their last values.
  - o_pixelVAL, o_sof, o_eof and o_mem_req are strictly single-cycle pulses.
- Timing: i_start at edge n gives o_mem_req at n+1. i_mem_rvalid at edge k gives o_pixelVAL at k+1.
- Per-pixel period = 2 + memory latency + PIX_GAP cycles. With 1-cycle latency and PIX_GAP=2, that is 5 cycles.
- Ignored inputs:
  - i_mem_rvalid outside WAIT is ignored.
  - i_track_valid outside WAIT_TRK is ignored; it does not pre-arm the handshake.
  - i_start deasserting mid-frame has no effect; the frame completes.
- Single-pixel frame (H_ACT=V_ACT=1): o_sof and o_eof assert in the same cycle.

Test Plan:
- Reset/idle: hold rst_n=0 with i_start=1 and toggle i_mem_rvalid → all outputs 0, no o_mem_req. Release with i_start=0 → remains IDLE, o_busy=0.
- Single frame, H_ACT=4, V_ACT=2, PIX_GAP=2, 1-cycle memory returning data=addr*0x010101:
  - 8 o_pixelVAL pulses, 5 cycles apart.
  - o_RGB sequence 0x000000..0x070707.
  - (H,V) goes (0,0)..(3,0),(0,1)..(3,1).
  - o_sof on the 1st pulse, o_eof on the 8th.
- Track handshake: after o_eof, delay i_track_valid 20 cycles with i_start=0 → no o_mem_req in that window. o_frame_cnt goes 0→1, then IDLE with o_busy=0.
- Continuous mode, PIX_GAP=0, memory latency randomized 1–5:
  - Hold i_start=1 for 3 frames → o_frame_cnt=3.
  - Address restarts at 0 each frame.
  - Never more than one outstanding request.
  - Pixel spacing = 2+latency.
- Spurious inputs: pulse i_mem_rvalid during GAP and i_track_valid during EMIT → no extra pixels, no early frame completion.
- Reset mid-frame: assert rst_n=0 after pixel (2,1) while in WAIT → outputs 0 immediately. The late rvalid is ignored. A new i_start restarts at address 0 with o_sof asserted.

Source files
------------

// File: rtl/pixel_frame_streamer.sv
// Transmit side of the Tracker pixel interface: fetches one frame from the
// frame buffer in raster order and emits each pixel as a single-cycle beat.
`timescale 1ns/1ps

module pixel_frame_streamer #(
  parameter int H_ACT   = 640,
  parameter int V_ACT   = 480,
  parameter int ADDR_W  = 19,  // 2**ADDR_W must cover H_ACT*V_ACT
  parameter int PIX_GAP = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  output logic              o_mem_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic              i_mem_rvalid,
  input  logic [23:0]       i_mem_rdata,
  output logic [23:0]       o_RGB,
  output logic              o_pixelVAL,
  output logic [9:0]        o_pixH,
  output logic [9:0]        o_pixV,
  output logic              o_sof,
  output logic              o_eof,
  input  logic              i_track_valid,
  output logic              o_busy,
  output logic [15:0]       o_frame_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_EMIT,
    S_GAP,
    S_WAIT_TRK
  } state_e;

  localparam logic [9:0] H_LAST = 10'(H_ACT - 1);
  localparam logic [9:0] V_LAST = 10'(V_ACT - 1);
  localparam int GAP_W = (PIX_GAP > 1) ? $clog2(PIX_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((PIX_GAP > 0) ? PIX_GAP - 1 : 0);

  state_e              state_q;
  logic [9:0]          h_q;        // coordinates of the next pixel to fetch
  logic [9:0]          v_q;
  logic [ADDR_W-1:0]   addr_q;     // linear address, tracks v_q*H_ACT+h_q
  logic [GAP_W-1:0]    gap_q;
  logic                last_q;     // final pixel of the frame has been emitted
  logic                mem_req_q;
  logic [23:0]         rgb_q;
  logic                pix_val_q;
  logic [9:0]          pix_h_q;
  logic [9:0]          pix_v_q;
  logic                sof_q;
  logic                eof_q;
  logic                busy_q;
  logic [15:0]         frame_cnt_q;

  // NOTE: all state and outputs are registers updated with non-blocking
  // assignments, so every branch below sees the values from the previous cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      h_q         <= '0;
      v_q         <= '0;
      addr_q      <= '0;
      gap_q       <= '0;
      last_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      rgb_q       <= '0;
      pix_val_q   <= 1'b0;
      pix_h_q     <= '0;
      pix_v_q     <= '0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
      busy_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      // Strobes default low so each one is a single-cycle pulse.
      mem_req_q <= 1'b0;
      pix_val_q <= 1'b0;
      sof_q     <= 1'b0;
      eof_q     <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            h_q       <= '0;
            v_q       <= '0;
            addr_q    <= '0;
            last_q    <= 1'b0;
            mem_req_q <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= S_REQ;
          end
        end

        S_REQ: state_q <= S_WAIT;

        S_WAIT: begin
          if (i_mem_rvalid) begin
            rgb_q     <= i_mem_rdata;
            pix_val_q <= 1'b1;
            pix_h_q   <= h_q;
            pix_v_q   <= v_q;
            sof_q     <= (h_q == '0) && (v_q == '0);
            eof_q     <= (h_q == H_LAST) && (v_q == V_LAST);
            state_q   <= S_EMIT;
          end
        end

        S_EMIT: begin
          addr_q <= addr_q + 1'b1;
          if (h_q == H_LAST) begin
            h_q <= '0;
            v_q <= v_q + 1'b1;
          end else begin
            h_q <= h_q + 1'b1;
          end
          last_q <= eof_q;
          gap_q  <= '0;
          if (PIX_GAP > 0) begin
            state_q <= S_GAP;
          end else if (eof_q) begin
            state_q <= S_WAIT_TRK;
          end else begin
            mem_req_q <= 1'b1;
            state_q   <= S_REQ;
          end
        end

        S_GAP: begin
          if (gap_q == GAP_LAST) begin
            if (last_q) begin
              state_q <= S_WAIT_TRK;
            end else begin
              mem_req_q <= 1'b1;
              state_q   <= S_REQ;
            end
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end

        S_WAIT_TRK: begin
          if (i_track_valid) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
            if (i_start) begin
              h_q       <= '0;
              v_q       <= '0;
              addr_q    <= '0;
              last_q    <= 1'b0;
              mem_req_q <= 1'b1;
              state_q   <= S_REQ;
            end else begin
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end
          end
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign o_mem_req   = mem_req_q;
  assign o_mem_addr  = addr_q;
  assign o_RGB       = rgb_q;
  assign o_pixelVAL  = pix_val_q;
  assign o_pixH      = pix_h_q;
  assign o_pixV      = pix_v_q;
  assign o_sof       = sof_q;
  assign o_eof       = eof_q;
  assign o_busy      = busy_q;
  assign o_frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_pixel_frame_streamer.sv
// Bench for pixel_frame_streamer: a 4x2 frame on two instances (PIX_GAP=2 and
// PIX_GAP=0) with a frame-level model compared against the DUT every cycle.
`timescale 1ns/1ps

module tb_pixel_frame_streamer;

  localparam int H     = 4;
  localparam int V     = 2;
  localparam int AW    = 3;
  localparam int FRAME = H * V;
  localparam int GAP_A = 2;
  localparam int GAP_B = 0;

  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic          rst_n;
  logic          start  [2];
  logic          rvalid [2];
  logic [23:0]   rdata  [2];
  logic          track  [2];
  logic          req    [2];
  logic [AW-1:0] addr   [2];
  logic [23:0]   rgb    [2];
  logic          pv     [2];
  logic [9:0]    ph     [2];
  logic [9:0]    pvv    [2];
  logic          sof    [2];
  logic          eof    [2];
  logic          busy   [2];
  logic [15:0]   fcnt   [2];

  pixel_frame_streamer #(.H_ACT(H), .V_ACT(V), .ADDR_W(AW), .PIX_GAP(GAP_A)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .i_start(start[0]),
    .o_mem_req(req[0]), .o_mem_addr(addr[0]),
    .i_mem_rvalid(rvalid[0]), .i_mem_rdata(rdata[0]),
    .o_RGB(rgb[0]), .o_pixelVAL(pv[0]), .o_pixH(ph[0]), .o_pixV(pvv[0]),
    .o_sof(sof[0]), .o_eof(eof[0]), .i_track_valid(track[0]),
    .o_busy(busy[0]), .o_frame_cnt(fcnt[0])
  );

  pixel_frame_streamer #(.H_ACT(H), .V_ACT(V), .ADDR_W(AW), .PIX_GAP(GAP_B)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .i_start(start[1]),
    .o_mem_req(req[1]), .o_mem_addr(addr[1]),
    .i_mem_rvalid(rvalid[1]), .i_mem_rdata(rdata[1]),
    .o_RGB(rgb[1]), .o_pixelVAL(pv[1]), .o_pixH(ph[1]), .o_pixV(pvv[1]),
    .o_sof(sof[1]), .o_eof(eof[1]), .i_track_valid(track[1]),
    .o_busy(busy[1]), .o_frame_cnt(fcnt[1])
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Frame-level model state, one slot per instance.
  int          cyc = 0;
  int          pix_idx [2] = '{0, 0};
  int          pix_cnt [2] = '{0, 0};
  int          req_cnt [2] = '{0, 0};
  int          req_cyc [2] = '{0, 0};
  int          pix_cyc [2] = '{0, 0};
  int          trk_from[2] = '{0, 0};
  int          lat_now [2] = '{1, 1};
  bit          outst   [2] = '{0, 0};
  bit          pending [2] = '{0, 0};
  logic [15:0] exp_cnt [2] = '{16'd0, 16'd0};
  logic [23:0] last_rgb[2] = '{24'd0, 24'd0};
  int          last_h  [2] = '{0, 0};
  int          last_v  [2] = '{0, 0};
  int          pulse_cyc_a[$];

  function automatic int gap_of(input int d);
    return (d == 0) ? GAP_A : GAP_B;
  endfunction

  task automatic model_cycle(input int d);
    string t;
    t = (d == 0) ? "a" : "b";
    if (!rst_n) begin
      check({t, "_rst_rgb"}, 32'(rgb[d]), 32'd0);
      check({t, "_rst_ctl"}, 32'({pv[d], req[d], sof[d], eof[d], busy[d], addr[d]}), 32'd0);
      check({t, "_rst_hv"}, 32'({ph[d], pvv[d]}), 32'd0);
      check({t, "_rst_cnt"}, 32'(fcnt[d]), 32'd0);
      pix_idx[d]  = 0;
      outst[d]    = 1'b0;
      pending[d]  = 1'b0;
      exp_cnt[d]  = '0;
      last_rgb[d] = '0;
      last_h[d]   = 0;
      last_v[d]   = 0;
      return;
    end

    check({t, "_frame_cnt"}, 32'(fcnt[d]), 32'(exp_cnt[d]));
    if (track[d] && pending[d] && cyc >= trk_from[d]) begin
      exp_cnt[d]++;
      pending[d] = 1'b0;
    end

    if (req[d]) begin
      req_cnt[d]++;
      check({t, "_req_single_outstanding"}, 32'(outst[d]), 32'd0);
      check({t, "_req_before_track"}, 32'(pending[d]), 32'd0);
      check({t, "_req_addr"}, 32'(addr[d]), pix_idx[d]);
      if (pix_idx[d] > 0) check({t, "_pix_to_req"}, cyc - pix_cyc[d], 1 + gap_of(d));
      outst[d]   = 1'b1;
      req_cyc[d] = cyc;
    end

    if (pv[d]) begin
      int n;
      n = pix_idx[d];
      check({t, "_pix_has_req"}, 32'(outst[d]), 32'd1);
      check({t, "_req_to_pix"}, cyc - req_cyc[d], 1 + lat_now[d]);
      check({t, "_rgb"}, 32'(rgb[d]), n * 32'h010101);
      check({t, "_pixH"}, 32'(ph[d]), n % H);
      check({t, "_pixV"}, 32'(pvv[d]), n / H);
      check({t, "_sof"}, 32'(sof[d]), 32'(n == 0));
      check({t, "_eof"}, 32'(eof[d]), 32'(n == FRAME - 1));
      last_rgb[d] = 24'(n * 32'h010101);
      last_h[d]   = n % H;
      last_v[d]   = n / H;
      outst[d]    = 1'b0;
      pix_cyc[d]  = cyc;
      pix_cnt[d]++;
      if (d == 0) pulse_cyc_a.push_back(cyc);
      if (n == FRAME - 1) begin
        pending[d]  = 1'b1;
        trk_from[d] = cyc + gap_of(d) + 1;
      end
      pix_idx[d] = (n + 1) % FRAME;
    end else begin
      check({t, "_hold_rgb"}, 32'(rgb[d]), 32'(last_rgb[d]));
      check({t, "_hold_hv"}, 32'({ph[d], pvv[d]}), 32'({10'(last_h[d]), 10'(last_v[d])}));
      check({t, "_idle_sof_eof"}, 32'({sof[d], eof[d]}), 32'd0);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    for (int d = 0; d < 2; d++) model_cycle(d);
  end

  // Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Acts as the frame-buffer memory: answers npix requests with data = addr*0x010101.
  task automatic serve(input int d, input int npix, input int lmin, input int lmax, input bit spur);
    for (int i = 0; i < npix; i++) begin
      int budget;
      int l;
      logic [AW-1:0] a;
      budget = 0;
      while (!req[d] && budget < 40) begin
        step();
        budget++;
      end
      if (!req[d]) begin
        check("req_timeout", 32'(req[d]), 32'd1);
        return;
      end
      a          = addr[d];
      l          = int'($urandom_range(lmax, lmin));
      lat_now[d] = l;
      repeat (l) step();
      rvalid[d] = 1'b1;
      rdata[d]  = 24'(a) * 24'h010101;
      step();
      rvalid[d] = 1'b0;
      if (spur) begin
        track[d] = 1'b1;   // lands in EMIT
        step();
        track[d]  = 1'b0;
        rvalid[d] = 1'b1;  // lands in GAP
        rdata[d]  = 24'hdead00;
        step();
        rvalid[d] = 1'b0;
      end
    end
  endtask

  task automatic pulse_track(input int d);
    track[d] = 1'b1;
    step();
    track[d] = 1'b0;
  endtask

  task automatic kick(input int d);
    start[d] = 1'b1;
    step();
    start[d] = 1'b0;
  endtask

  initial begin
    int r0;
    int p0;
    int budget;
    // NOTE: stimulus is driven with blocking assignments from this single
    // process, away from the sampling edge, so DUT and bench never race.
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      start[d]  = 1'b1;
      rvalid[d] = 1'b0;
      rdata[d]  = 24'h123456;
      track[d]  = 1'b0;
    end

    // Reset held with i_start high and rvalid toggling.
    for (int i = 0; i < 6; i++) begin
      rvalid[0] = i[0];
      rvalid[1] = i[0];
      step();
    end
    rvalid[0] = 1'b0;
    rvalid[1] = 1'b0;
    start[0]  = 1'b0;
    start[1]  = 1'b0;
    rst_n     = 1'b1;
    repeat (5) step();
    check("idle_busy_a", 32'(busy[0]), 32'd0);
    check("idle_busy_b", 32'(busy[1]), 32'd0);
    check("idle_no_req_a", req_cnt[0], 0);
    check("idle_no_req_b", req_cnt[1], 0);

    // Single frame, 1-cycle memory, PIX_GAP=2.
    kick(0);
    serve(0, FRAME, 1, 1, 1'b0);
    step();
    check("a_pulse_count", pulse_cyc_a.size(), FRAME);
    for (int i = 1; i < pulse_cyc_a.size(); i++)
      check("a_pulse_spacing", pulse_cyc_a[i] - pulse_cyc_a[i-1], 5);
    check("a_last_rgb", 32'(rgb[0]), 32'h070707);
    check("a_last_h", 32'(ph[0]), 32'd3);
    check("a_last_v", 32'(pvv[0]), 32'd1);

    // Delayed track handshake.
    r0 = req_cnt[0];
    repeat (20) step();
    check("a_no_req_in_wait_trk", req_cnt[0] - r0, 0);
    check("a_busy_in_wait_trk", 32'(busy[0]), 32'd1);
    check("a_cnt_before_track", 32'(fcnt[0]), 32'd0);
    pulse_track(0);
    step();
    check("a_cnt_after_track", 32'(fcnt[0]), 32'd1);
    check("a_idle_after_frame", 32'(busy[0]), 32'd0);

    // Spurious rvalid in GAP and track_valid in EMIT.
    kick(0);
    serve(0, FRAME, 1, 3, 1'b1);
    repeat (3) step();
    check("a_spur_pixels", pix_cnt[0], 2 * FRAME);
    check("a_spur_no_early_done", 32'(fcnt[0]), 32'd1);
    pulse_track(0);
    step();
    check("a_spur_cnt", 32'(fcnt[0]), 32'd2);

    // Continuous mode on PIX_GAP=0 instance, latency 1..5; i_start drops mid frame 3.
    start[1] = 1'b1;
    for (int f = 0; f < 3; f++) begin
      if (f == 2) start[1] = 1'b0;
      serve(1, FRAME, 1, 5, 1'b0);
      step();
      pulse_track(1);
    end
    step();
    check("b_frames", 32'(fcnt[1]), 32'd3);
    check("b_idle", 32'(busy[1]), 32'd0);
    check("b_pixels", pix_cnt[1], 3 * FRAME);

    // Reset while waiting for pixel 7, right after pixel (2,1).
    kick(0);
    serve(0, 7, 1, 1, 1'b0);
    budget = 0;
    while (!req[0] && budget < 40) begin
      step();
      budget++;
    end
    check("a_req_before_reset", 32'(addr[0]), 32'd7);
    step();
    rst_n = 1'b0;
    #1;
    check("a_rst_rgb_now", 32'(rgb[0]), 32'd0);
    check("a_rst_hv_now", 32'({ph[0], pvv[0]}), 32'd0);
    check("a_rst_addr_now", 32'(addr[0]), 32'd0);
    check("a_rst_cnt_now", 32'(fcnt[0]), 32'd0);
    check("a_rst_busy_now", 32'(busy[0]), 32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    p0 = pix_cnt[0];
    rvalid[0] = 1'b1;
    rdata[0]  = 24'h070707;
    step();
    rvalid[0] = 1'b0;
    repeat (3) step();
    check("a_late_rvalid_ignored", pix_cnt[0] - p0, 0);
    check("a_late_rvalid_idle", 32'(busy[0]), 32'd0);

    kick(0);
    serve(0, FRAME, 1, 1, 1'b0);
    repeat (3) step();
    check("a_restart_pixels", pix_cnt[0] - p0, FRAME);
    check("a_restart_last_rgb", 32'(rgb[0]), 32'h070707);
    pulse_track(0);
    step();
    check("a_restart_cnt", 32'(fcnt[0]), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
